// File: rtl/pcie_msi_scheduler.sv
// Shares the function-0 MSI port of the PCIe hard block between NUM_IRQ requesters:
// latches/coalesces requests, round-robin selects, issues one MSI at a time, retries on fail/timeout.
module pcie_msi_scheduler #(
   parameter int unsigned NUM_IRQ        = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned BACKOFF_CYCLES = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_req,
   output logic [NUM_IRQ-1:0] irq_pending,
   input  logic [3:0]         cfg_interrupt_msi_enable,
   input  logic [11:0]        cfg_interrupt_msi_mmenable,
   output logic [31:0]        cfg_interrupt_msi_int,
   input  logic               cfg_interrupt_msi_sent,
   input  logic               cfg_interrupt_msi_fail,
   output logic [3:0]         cfg_interrupt_msi_function_number,
   output logic [15:0]        fail_count
);

   localparam int unsigned IDXW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
   localparam int unsigned TMAX = (TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES : BACKOFF_CYCLES;
   localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_BACKOFF
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [IDXW-1:0]    ptr_q, ptr_d;
   logic [IDXW-1:0]    cur_q, cur_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic [15:0]        fail_cnt_q, fail_cnt_d;

   logic               sel_found;
   logic [IDXW-1:0]    sel_idx;
   logic [IDXW-1:0]    cur_next;
   logic [4:0]         vec_max;
   logic [4:0]         vec;
   logic               delivery_failed;
   logic               unused_cfg;

   assign unused_cfg = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

   function automatic int unsigned wrap_idx(input int unsigned a);
      return (a >= NUM_IRQ) ? a - NUM_IRQ : a;
   endfunction

   // First pending index at or above the pointer, wrapping around.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int unsigned k = 0; k < NUM_IRQ; k++) begin
         if (!sel_found && pending_q[IDXW'(wrap_idx(32'(ptr_q) + k))]) begin
            sel_found = 1'b1;
            sel_idx   = IDXW'(wrap_idx(32'(ptr_q) + k));
         end
      end
   end

   assign cur_next = (32'(cur_q) == NUM_IRQ - 1) ? '0 : cur_q + IDXW'(1);

   // Requesters above the granted vector count all alias onto the top granted vector.
   always_comb begin
      vec_max = 5'd31;
      case (cfg_interrupt_msi_mmenable[2:0])
         3'd0:    vec_max = 5'd0;
         3'd1:    vec_max = 5'd1;
         3'd2:    vec_max = 5'd3;
         3'd3:    vec_max = 5'd7;
         3'd4:    vec_max = 5'd15;
         default: vec_max = 5'd31;
      endcase
      vec = (32'(cur_q) > 32'(vec_max)) ? vec_max : 5'(cur_q);
   end

   assign cfg_interrupt_msi_int             = (state_q == S_ISSUE) ? (32'd1 << vec) : '0;
   assign cfg_interrupt_msi_function_number = '0;
   assign irq_pending                       = pending_q;
   assign fail_count                        = fail_cnt_q;

   assign delivery_failed = cfg_interrupt_msi_fail ||
                            (!cfg_interrupt_msi_sent && (timer_q <= TW'(1)));

   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      ptr_d      = ptr_q;
      cur_d      = cur_q;
      timer_d    = timer_q;
      fail_cnt_d = fail_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (cfg_interrupt_msi_enable[0] && sel_found) begin
               cur_d   = sel_idx;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            pending_d[cur_q] = 1'b0;
            timer_d          = TW'(TIMEOUT_CYCLES);
            state_d          = S_WAIT;
         end
         S_WAIT: begin
            if (delivery_failed) begin
               pending_d[cur_q] = 1'b1;
               if (fail_cnt_q != 16'hFFFF) begin
                  fail_cnt_d = fail_cnt_q + 16'd1;
               end
               ptr_d   = cur_next;
               timer_d = TW'(BACKOFF_CYCLES);
               state_d = S_BACKOFF;
            end else if (cfg_interrupt_msi_sent) begin
               ptr_d   = cur_next;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_BACKOFF: begin
            if (timer_q <= TW'(1)) begin
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A new request in the same cycle as the issue-clear must survive.
      pending_d = pending_d | irq_req;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pending_q  <= '0;
         ptr_q      <= '0;
         cur_q      <= '0;
         timer_q    <= '0;
         fail_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         ptr_q      <= ptr_d;
         cur_q      <= cur_d;
         timer_q    <= timer_d;
         fail_cnt_q <= fail_cnt_d;
      end
   end

endmodule

// File: tb/tb_pcie_msi_scheduler.sv
// Scoreboard bench for pcie_msi_scheduler: stimulus pushes expected MSI vectors, a monitor pops on each pulse.
module tb_pcie_msi_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  irq_req;
   logic [7:0]  irq_pending;
   logic [3:0]  msi_enable;
   logic [11:0] msi_mmenable;
   logic [31:0] msi_int;
   logic        msi_sent;
   logic        msi_fail;
   logic [3:0]  msi_fnum;
   logic [15:0] fail_count;

   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pcie_msi_scheduler #(
      .NUM_IRQ(8),
      .TIMEOUT_CYCLES(1024),
      .BACKOFF_CYCLES(64)
   ) dut (
      .clk                               (clk),
      .rst                               (rst),
      .irq_req                           (irq_req),
      .irq_pending                       (irq_pending),
      .cfg_interrupt_msi_enable          (msi_enable),
      .cfg_interrupt_msi_mmenable        (msi_mmenable),
      .cfg_interrupt_msi_int             (msi_int),
      .cfg_interrupt_msi_sent            (msi_sent),
      .cfg_interrupt_msi_fail            (msi_fail),
      .cfg_interrupt_msi_function_number (msi_fnum),
      .fail_count                        (fail_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_ge(input string name, input int act, input int min);
      checks++;
      if (act < min) begin
         errors++;
         $display("FAIL %s: got %0d expected >= %0d", name, act, min);
      end
   endtask

   // Monitor: every nonzero MSI pulse must match the oldest expected vector.
   always @(negedge clk) begin
      if (msi_int !== 32'h0) begin
         if (exp_q.size() == 0) chk("unexpected_int", msi_int, 32'h0);
         else chk("int_vector", msi_int, exp_q.pop_front());
      end
   end

   task automatic pulse_req(input logic [7:0] v, output int at);
      @(negedge clk);
      irq_req = v;
      at = cyc;
      @(negedge clk);
      irq_req = '0;
   endtask

   task automatic wait_int(input string name, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (msi_int !== 32'h0) begin
            at = cyc;
            break;
         end
      end
      checks++;
      if (at < 0) begin
         errors++;
         $display("FAIL %s: no int within %0d cycles", name, budget);
      end
   endtask

   task automatic reply(input int delay, input bit is_fail);
      repeat (delay) @(negedge clk);
      msi_sent = !is_fail;
      msi_fail = is_fail;
      @(negedge clk);
      msi_sent = 1'b0;
      msi_fail = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, t1, t2, t3, n;
      rst          = 1'b1;
      irq_req      = '0;
      msi_enable   = 4'h1;
      msi_mmenable = 12'h3;
      msi_sent     = 1'b0;
      msi_fail     = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_int", msi_int, 32'h0);
      chk("reset_pending", 32'(irq_pending), 32'h0);
      chk("reset_fail_count", 32'(fail_count), 32'h0);
      chk("reset_fnum", 32'(msi_fnum), 32'h0);
      rst = 1'b0;

      // Single request: vector 3 with 8 vectors granted
      exp_q.push_back(32'h8);
      pulse_req(8'h08, n);
      wait_int("single", 10, t);
      chk("single_latency", 32'(t - n), 32'd2);
      reply(5, 1'b0);
      repeat (3) @(negedge clk);
      chk("single_pending", 32'(irq_pending), 32'h0);

      // Round-robin from pointer 0
      do_reset();
      for (int i = 0; i < 8; i++) exp_q.push_back(32'h1 << i);
      pulse_req(8'hFF, n);
      for (int i = 0; i < 8; i++) begin
         wait_int("rr", 20, t);
         reply(3, 1'b0);
      end
      repeat (10) @(negedge clk);
      chk("rr_drained", 32'(exp_q.size()), 32'h0);
      chk("rr_pending", 32'(irq_pending), 32'h0);

      // Aliasing onto granted vectors
      do_reset();
      msi_mmenable = 12'h1;
      exp_q.push_back(32'h2);
      pulse_req(8'h20, n);
      wait_int("alias5", 20, t);
      reply(2, 1'b0);
      exp_q.push_back(32'h1);
      pulse_req(8'h01, n);
      wait_int("alias0", 20, t);
      reply(2, 1'b0);
      msi_mmenable = 12'h0;
      exp_q.push_back(32'h1);
      pulse_req(8'h40, n);
      wait_int("alias_single", 20, t);
      reply(2, 1'b0);
      msi_mmenable = 12'h7;
      exp_q.push_back(32'h80);
      pulse_req(8'h80, n);
      wait_int("alias_cap32", 20, t);
      reply(2, 1'b0);
      msi_mmenable = 12'h3;

      // Fail, backoff and timeout retries
      do_reset();
      exp_q.push_back(32'h4);
      pulse_req(8'h04, n);
      wait_int("fail_first", 20, t1);
      reply(2, 1'b1);
      chk("fail_count_1", 32'(fail_count), 32'd1);
      chk("fail_repending", 32'(irq_pending), 32'h4);
      exp_q.push_back(32'h4);
      wait_int("fail_retry", 200, t2);
      chk_ge("backoff_gap", t2 - t1, 64);
      exp_q.push_back(32'h4);
      wait_int("timeout_retry", 1300, t3);
      chk_ge("timeout_gap", t3 - t2, 1024 + 64);
      chk("fail_count_2", 32'(fail_count), 32'd2);
      reply(2, 1'b0);
      repeat (3) @(negedge clk);
      chk("fail_pending_clear", 32'(irq_pending), 32'h0);
      chk("fail_count_hold", 32'(fail_count), 32'd2);

      // Gating and coalescing
      do_reset();
      msi_enable = 4'h0;
      for (int i = 0; i < 3; i++) begin
         pulse_req(8'h02, n);
         repeat (2) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      chk("gate_pending", 32'(irq_pending), 32'h2);
      exp_q.push_back(32'h2);
      msi_enable = 4'h1;
      wait_int("gate_release", 20, t);
      reply(2, 1'b0);
      repeat (20) @(negedge clk);
      chk("gate_pending_clear", 32'(irq_pending), 32'h0);
      chk("gate_one_int", 32'(exp_q.size()), 32'h0);

      // Reset while waiting for a reply
      do_reset();
      exp_q.push_back(32'h1);
      pulse_req(8'h01, n);
      wait_int("midrst_issue", 20, t);
      @(negedge clk);
      pulse_req(8'h30, n);
      chk("midrst_pending", 32'(irq_pending), 32'h30);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_int", msi_int, 32'h0);
      chk("midrst_pend0", 32'(irq_pending), 32'h0);
      chk("midrst_fail0", 32'(fail_count), 32'h0);
      chk("midrst_fnum", 32'(msi_fnum), 32'h0);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      exp_q.push_back(32'h40);
      pulse_req(8'h40, n);
      wait_int("midrst_new", 20, t);
      reply(2, 1'b0);

      repeat (5) @(negedge clk);
      chk("final_drained", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
